// File: rtl/barrett_final_reduce.sv
`timescale 1ns/1ps
// barrett_final_reduce
// Final stage after the Barrett digit iterations. A chunked carry-propagate add
// collapses the carry-save residue (ZS, ZC) into Z. Bounded conditional
// subtraction of M then brings Z into [0, M), or flags err if the bound runs out.
// Start/busy/done handshake toward the multiplication controller.
module barrett_final_reduce #(
    parameter int N       = 1024,
    parameter int M_DIG   = 4,
    parameter int CHUNK   = 64,
    parameter int MAX_SUB = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [N+M_DIG+12-1:0]   ZS,
    input  logic [N+M_DIG+12-1:0]   ZC,
    input  logic [N-1:0]            Mod,
    output logic                    busy,
    output logic                    done,
    output logic [N-1:0]            R,
    output logic                    err
);

    localparam int ZW  = N + M_DIG + 12;
    localparam int NCH = (ZW + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = (MAX_SUB > 0) ? $clog2(MAX_SUB + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SUB,
        S_FIN
    } state_t;

    // Keeps only the bits of chunk c that lie below ZW, so the sum wraps mod 2^ZW
    function automatic logic [CHUNK-1:0] chunk_mask(input int c);
        logic [CHUNK-1:0] m;
        for (int j = 0; j < CHUNK; j++) begin
            m[j] = ((c * CHUNK + j) < ZW);
        end
        return m;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;

    // Operands and working residue, zero-padded to a whole number of chunks
    logic [PW-1:0]    r_zs;
    logic [PW-1:0]    r_zc;
    logic [PW-1:0]    r_m;
    logic [PW-1:0]    r_z;
    logic [PW-1:0]    r_d;
    logic             r_cy;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [N-1:0]     r_res;

    logic [CHUNK-1:0] w_zs_ch;
    logic [CHUNK-1:0] w_zc_ch;
    logic [CHUNK-1:0] w_z_ch;
    logic [CHUNK-1:0] w_m_ch;
    logic [CHUNK-1:0] w_mask;
    logic [CHUNK:0]   w_add;
    logic [CHUNK:0]   w_sub;
    logic             w_borrow;
    logic             w_last;
    logic [PW-1:0]    w_z_upd;
    logic [PW-1:0]    w_d_upd;
    logic             w_commit;
    logic             w_overrun;
    logic             w_to_fin;

    assign w_last = (r_idx == IW'(NCH - 1));

    // Select the current chunk of every operand
    always_comb begin
        w_zs_ch = '0;
        w_zc_ch = '0;
        w_z_ch  = '0;
        w_m_ch  = '0;
        w_mask  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r_idx == IW'(c)) begin
                w_zs_ch = r_zs[c*CHUNK +: CHUNK];
                w_zc_ch = r_zc[c*CHUNK +: CHUNK];
                w_z_ch  = r_z[c*CHUNK +: CHUNK];
                w_m_ch  = r_m[c*CHUNK +: CHUNK];
                w_mask  = chunk_mask(c);
            end
        end
    end

    // One chunk of add (carry in/out) and subtract (borrow in/out) share r_cy;
    // a negative difference shows up as a set top bit, which is the borrow out
    assign w_add    = {1'b0, w_zs_ch} + {1'b0, w_zc_ch} + {{CHUNK{1'b0}}, r_cy};
    assign w_sub    = {1'b0, w_z_ch} - {1'b0, w_m_ch} - {{CHUNK{1'b0}}, r_cy};
    assign w_borrow = w_sub[CHUNK];

    // Splice the freshly computed chunk into the sum and difference vectors
    always_comb begin
        w_z_upd = r_z;
        w_d_upd = r_d;
        for (int c = 0; c < NCH; c++) begin
            if (r_idx == IW'(c)) begin
                w_z_upd[c*CHUNK +: CHUNK] = w_add[CHUNK-1:0] & w_mask;
                w_d_upd[c*CHUNK +: CHUNK] = w_sub[CHUNK-1:0];
            end
        end
    end

    // Next-state decode; a pass decision is made only on its last chunk
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                if (w_last) begin
                    w_state_nxt = S_SUB;
                end
            end
            S_SUB: begin
                if (w_last) begin
                    if (w_borrow) begin
                        w_state_nxt = S_FIN;
                    end else if (r_cnt != CW'(MAX_SUB)) begin
                        w_commit = 1'b1;
                    end else begin
                        w_overrun   = 1'b1;
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_to_fin = (r_state == S_SUB) && (w_state_nxt == S_FIN);

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, chunk sequencing, residue update and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_zs   <= '0;
            r_zc   <= '0;
            r_m    <= '0;
            r_z    <= '0;
            r_d    <= '0;
            r_cy   <= 1'b0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_res  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_zs   <= PW'(ZS);
                        r_zc   <= PW'(ZC);
                        r_m    <= PW'(Mod);
                        r_cy   <= 1'b0;
                        r_idx  <= '0;
                        r_cnt  <= '0;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                S_ADD: begin
                    r_z   <= w_z_upd;
                    // Carry out of the top chunk is discarded: the sum wraps mod 2^ZW
                    r_cy  <= w_last ? 1'b0 : w_add[CHUNK];
                    r_idx <= w_last ? '0 : r_idx + IW'(1);
                end
                S_SUB: begin
                    r_d   <= w_d_upd;
                    r_cy  <= w_last ? 1'b0 : w_borrow;
                    r_idx <= w_last ? '0 : r_idx + IW'(1);
                    if (w_commit) begin
                        r_z   <= w_d_upd;
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_to_fin) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_res  <= r_z[N-1:0];
                        r_err  <= w_overrun;
                    end
                end
                S_FIN: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign R    = r_res;
    assign err  = r_err;

endmodule

// File: tb/tb_barrett_final_reduce.sv
`timescale 1ns/1ps
// Testbench for barrett_final_reduce at N=16, M_DIG=4 (ZW=32), CHUNK=8 (NCH=4),
// MAX_SUB=3. Expected results are queued when a start is driven and popped
// when the DUT pulses done.
module tb_barrett_final_reduce;

    localparam int N       = 16;
    localparam int M_DIG   = 4;
    localparam int CHUNK   = 8;
    localparam int MAX_SUB = 3;
    localparam int ZW      = 32;
    localparam int NCH     = 4;

    typedef struct {
        logic [15:0] r;
        logic        e;
        int          lat;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [31:0]   ZS;
    logic [31:0]   ZC;
    logic [15:0]   Mod;
    logic          busy;
    logic          done;
    logic [15:0]   R;
    logic          err;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    barrett_final_reduce #(
        .N(N), .M_DIG(M_DIG), .CHUNK(CHUNK), .MAX_SUB(MAX_SUB)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .ZS(ZS), .ZC(ZC), .Mod(Mod),
        .busy(busy), .done(done), .R(R), .err(err)
    );

    // Reference: full-width add mod 2^32, then at most MAX_SUB subtractions
    function automatic exp_t model(input logic [31:0] zs, input logic [31:0] zc,
                                   input logic [15:0] m);
        exp_t        x;
        logic [31:0] z;
        int          k;
        bit          fin;
        z   = zs + zc;
        k   = 0;
        fin = 0;
        x.e = 1'b0;
        while (!fin) begin
            if (z < {16'd0, m}) begin
                fin = 1;
            end else if (k == MAX_SUB) begin
                x.e = 1'b1;
                fin = 1;
            end else begin
                z = z - {16'd0, m};
                k++;
            end
        end
        x.r   = z[15:0];
        x.lat = 1 + NCH * (2 + k);
        return x;
    endfunction

    // Start accepted at the next rising edge; operands scrambled afterwards
    task automatic launch(input logic [31:0] zs, input logic [31:0] zc,
                          input logic [15:0] m, input exp_t ex);
        @(negedge CLK);
        ZS    = zs;
        ZC    = zc;
        Mod   = m;
        start = 1'b1;
        sb.push_back(ex);
        @(posedge CLK);
        #1;
        start = 1'b0;
        ZS    = $urandom;
        ZC    = $urandom;
        Mod   = 16'($urandom);
    endtask

    // Waits (bounded) for done; counts cycles where busy/done disagree with an
    // operation in progress. Optionally pulses start at cycle 'inject'.
    task automatic run_to_done(input int inject, output int lat, output logic [15:0] r,
                               output logic e, output int bad);
        lat = -1;
        bad = 0;
        r   = 'x;
        e   = 1'bx;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (k == inject) begin
                start = 1'b1;
                ZS    = 32'd7;
                ZC    = 32'd9;
                Mod   = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = k;
                r   = R;
                e   = err;
                if (busy !== 1'b0) bad++;
                break;
            end
            if (busy !== 1'b1) bad++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset busy: got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset done: got %b want 0", done); end
        n_checks++;
        if (R !== 16'd0) begin n_errors++; $display("FAIL reset R: got %0d want 0", R); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL reset err: got %b want 0", err); end
    endtask

    task automatic test_subtract();
        logic [31:0] zs[3];
        logic [31:0] zc[3];
        logic [15:0] rr[3];
        logic        ee[3];
        int          ll[3];
        exp_t        ex;
        int          lat, bad;
        logic [15:0] r;
        logic        e;
        zs = '{32'd100, 32'd500, 32'd800};
        zc = '{32'd23, 32'd150, 32'd50};
        rr = '{16'd123, 16'd50, 16'd250};
        ee = '{1'b0, 1'b0, 1'b1};
        ll = '{9, 21, 21};
        for (int i = 0; i < 3; i++) begin
            ex.r = rr[i]; ex.e = ee[i]; ex.lat = ll[i];
            launch(zs[i], zc[i], 16'd200, ex);
            run_to_done(0, lat, r, e, bad);
            ex = sb.pop_front();
            n_checks++;
            if (lat !== ex.lat) begin n_errors++; $display("FAIL subtract[%0d] done cycle: got %0d want %0d", i, lat, ex.lat); end
            n_checks++;
            if (r !== ex.r) begin n_errors++; $display("FAIL subtract[%0d] R: got %0d want %0d", i, r, ex.r); end
            n_checks++;
            if (e !== ex.e) begin n_errors++; $display("FAIL subtract[%0d] err: got %b want %b", i, e, ex.e); end
            n_checks++;
            if (bad !== 0) begin n_errors++; $display("FAIL subtract[%0d] busy/done handshake: got %0d bad cycles want 0", i, bad); end
            @(negedge CLK);
            n_checks++;
            if (done !== 1'b0 || R !== ex.r) begin
                n_errors++;
                $display("FAIL subtract[%0d] after done: got done=%b R=%0d want done=0 R=%0d", i, done, R, ex.r);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] zs[3];
        logic [31:0] zc[3];
        logic [15:0] mm[3];
        logic [15:0] rr[3];
        logic        ee[3];
        int          ll[3];
        exp_t        ex;
        int          lat, bad;
        logic [15:0] r;
        logic        e;
        zs = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'd5};
        zc = '{32'h0000_0001, 32'h0000_0001, 32'd0};
        mm = '{16'h1000, 16'd7, 16'd0};
        rr = '{16'h0100, 16'd0, 16'd5};
        ee = '{1'b0, 1'b0, 1'b1};
        ll = '{9, 9, 21};
        for (int i = 0; i < 3; i++) begin
            ex.r = rr[i]; ex.e = ee[i]; ex.lat = ll[i];
            launch(zs[i], zc[i], mm[i], ex);
            run_to_done(0, lat, r, e, bad);
            ex = sb.pop_front();
            n_checks++;
            if (lat !== ex.lat) begin n_errors++; $display("FAIL boundary[%0d] done cycle: got %0d want %0d", i, lat, ex.lat); end
            n_checks++;
            if (r !== ex.r) begin n_errors++; $display("FAIL boundary[%0d] R: got %0h want %0h", i, r, ex.r); end
            n_checks++;
            if (e !== ex.e) begin n_errors++; $display("FAIL boundary[%0d] err: got %b want %b", i, e, ex.e); end
            n_checks++;
            if (bad !== 0) begin n_errors++; $display("FAIL boundary[%0d] busy/done handshake: got %0d bad cycles want 0", i, bad); end
        end
    endtask

    task automatic test_start_while_busy();
        exp_t        ex;
        int          lat, bad;
        logic [15:0] r;
        logic        e;
        ex.r = 16'd123; ex.e = 1'b0; ex.lat = 9;
        launch(32'd100, 32'd23, 16'd200, ex);
        run_to_done(3, lat, r, e, bad);
        ex = sb.pop_front();
        n_checks++;
        if (lat !== ex.lat) begin n_errors++; $display("FAIL busy_start done cycle: got %0d want %0d", lat, ex.lat); end
        n_checks++;
        if (r !== ex.r) begin n_errors++; $display("FAIL busy_start R: got %0d want %0d", r, ex.r); end
        n_checks++;
        if (e !== ex.e) begin n_errors++; $display("FAIL busy_start err: got %b want %b", e, ex.e); end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL busy_start handshake: got %0d bad cycles want 0", bad); end
        // The ignored request must not start a second operation
        @(negedge CLK);
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_start idle[%0d]: got busy=%b done=%b want 0 0", k, busy, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t        ex;
        int          lat, bad, seen;
        logic [15:0] r;
        logic        e;
        ex.r = 16'd123; ex.e = 1'b0; ex.lat = 9;
        launch(32'd100, 32'd23, 16'd200, ex);
        void'(sb.pop_front());
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || R !== 16'd0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid outputs: got busy=%b done=%b R=%0d err=%b want 0 0 0 0", busy, done, R, err);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST  = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_errors++; $display("FAIL reset_mid aborted op: got %0d active cycles want 0", seen); end
        ex.r = 16'd123; ex.e = 1'b0; ex.lat = 9;
        launch(32'd100, 32'd23, 16'd200, ex);
        run_to_done(0, lat, r, e, bad);
        ex = sb.pop_front();
        n_checks++;
        if (lat !== ex.lat) begin n_errors++; $display("FAIL reset_mid restart done cycle: got %0d want %0d", lat, ex.lat); end
        n_checks++;
        if (r !== ex.r || e !== ex.e) begin n_errors++; $display("FAIL reset_mid restart R/err: got %0d/%b want %0d/%b", r, e, ex.r, ex.e); end
    endtask

    task automatic test_back_to_back();
        exp_t        ex;
        int          lat, bad;
        logic [15:0] r;
        logic        e;
        logic [31:0] zs, zc;
        logic [15:0] m;
        for (int i = 0; i < 8; i++) begin
            zs = 32'($urandom_range(0, 3000));
            zc = 32'($urandom_range(0, 3000));
            m  = 16'($urandom_range(1, 2500));
            if (i == 7) begin
                zs = 32'hFFFF_F000;
                zc = 32'h0000_2345;
                m  = 16'hFFFF;
            end
            launch(zs, zc, m, model(zs, zc, m));
            run_to_done(0, lat, r, e, bad);
            ex = sb.pop_front();
            n_checks++;
            if (lat !== ex.lat) begin n_errors++; $display("FAIL b2b[%0d] done cycle: got %0d want %0d", i, lat, ex.lat); end
            n_checks++;
            if (r !== ex.r) begin n_errors++; $display("FAIL b2b[%0d] R: got %0d want %0d", i, r, ex.r); end
            n_checks++;
            if (e !== ex.e) begin n_errors++; $display("FAIL b2b[%0d] err: got %b want %b", i, e, ex.e); end
            n_checks++;
            if (bad !== 0) begin n_errors++; $display("FAIL b2b[%0d] handshake: got %0d bad cycles want 0", i, bad); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST   = 1'b0;
        start = 1'b0;
        ZS    = '0;
        ZC    = '0;
        Mod   = '0;
        repeat (3) @(negedge CLK);
        test_reset();
        RST = 1'b1;
        @(negedge CLK);
        test_subtract();
        test_boundaries();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (sb.size() !== 0) begin n_errors++; $display("FAIL scoreboard residue: got %0d entries want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
